// File: rtl/merlin_mem_arbiter.sv
// rtl/merlin_mem_arbiter.sv - ifetch/data arbiter onto one pipelined memory port with in-order response routing
// Optional round-robin arbitration: define MERLIN_MEM_ARB_RR_EN (default build is fixed data priority).
module merlin_mem_arbiter #(
  parameter int C_OUTSTANDING_X = 2,
  parameter int C_XLEN          = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       clk_en_i,
  input  logic                       ireqvalid_i,
  output logic                       ireqready_o,
  input  logic [1:0]                 ireqhpl_i,
  input  logic [C_XLEN-1:0]          ireqaddr_i,
  output logic                       irspvalid_o,
  input  logic                       irspready_i,
  output logic                       irsprerr_o,
  output logic [C_XLEN-1:0]          irspdata_o,
  input  logic                       dreqvalid_i,
  output logic                       dreqready_o,
  input  logic [1:0]                 dreqhpl_i,
  input  logic                       dreqwr_i,
  input  logic [C_XLEN/8-1:0]        dreqbe_i,
  input  logic [C_XLEN-1:0]          dreqaddr_i,
  input  logic [C_XLEN-1:0]          dreqwdata_i,
  output logic                       drspvalid_o,
  input  logic                       drspready_i,
  output logic                       drsprerr_o,
  output logic [C_XLEN-1:0]          drspdata_o,
  output logic                       mreqvalid_o,
  input  logic                       mreqready_i,
  output logic [1:0]                 mreqhpl_o,
  output logic                       mreqwr_o,
  output logic [C_XLEN/8-1:0]        mreqbe_o,
  output logic [C_XLEN-1:0]          mreqaddr_o,
  output logic [C_XLEN-1:0]          mreqwdata_o,
  input  logic                       mrspvalid_i,
  output logic                       mrspready_o,
  input  logic                       mrsprerr_i,
  input  logic [C_XLEN-1:0]          mrspdata_i,
  output logic [C_OUTSTANDING_X:0]   outstanding_o,
  output logic                       unexp_rsp_o
);

  localparam int DEPTH = 2**C_OUTSTANDING_X;
  localparam logic [C_OUTSTANDING_X:0] LEVEL_FULL = (C_OUTSTANDING_X+1)'(DEPTH);

  // Owner encoding: 0 = ifetch, 1 = data
  logic [DEPTH-1:0]           tag_q;
  logic [C_OUTSTANDING_X-1:0] wptr_q;
  logic [C_OUTSTANDING_X-1:0] rptr_q;
  logic [C_OUTSTANDING_X:0]   level_q;
  logic                       lock_q;
  logic                       grant_q;
  logic                       unexp_q;
`ifdef MERLIN_MEM_ARB_RR_EN
  logic                       last_q;
`endif

  logic act;
  logic full;
  logic empty;
  logic grant;
  logic req_valid;
  logic accept;
  logic head;
  logic pop;

  // Handshakes are suppressed while in reset or while the clock enable is low,
  // so nothing can be accepted in a cycle where the state would not record it.
  assign act   = clk_en_i & ~reset_i;
  assign full  = (level_q == LEVEL_FULL);
  assign empty = (level_q == '0);
  assign head  = tag_q[rptr_q];

  // Grant selection: a stalled request keeps its grant until accepted
  always_comb begin
    grant = dreqvalid_i;
    if (lock_q) begin
      grant = grant_q;
    end
`ifdef MERLIN_MEM_ARB_RR_EN
    else if (dreqvalid_i && ireqvalid_i) begin
      grant = ~last_q;
    end
`endif
  end

  // Request mux toward the memory port
  always_comb begin
    req_valid   = grant ? dreqvalid_i : ireqvalid_i;
    mreqvalid_o = act & req_valid & ~full;
    accept      = mreqvalid_o & mreqready_i;
    ireqready_o = accept & ~grant;
    dreqready_o = accept & grant;
    mreqhpl_o   = grant ? dreqhpl_i : ireqhpl_i;
    mreqwr_o    = grant & dreqwr_i;
    mreqbe_o    = grant ? dreqbe_i : '0;
    mreqaddr_o  = grant ? dreqaddr_i : ireqaddr_i;
    mreqwdata_o = grant ? dreqwdata_i : '0;
  end

  // Response routing by head tag; a stray response with no tag is drained
  always_comb begin
    irspvalid_o = act & mrspvalid_i & ~empty & ~head;
    drspvalid_o = act & mrspvalid_i & ~empty & head;
    mrspready_o = act & (empty ? 1'b1 : (head ? drspready_i : irspready_i));
    pop         = mrspvalid_i & mrspready_o & ~empty;
    irsprerr_o  = mrsprerr_i;
    drsprerr_o  = mrsprerr_i;
    irspdata_o  = mrspdata_i;
    drspdata_o  = mrspdata_i;
  end

  assign outstanding_o = level_q;
  assign unexp_rsp_o   = unexp_q;

  // Tag FIFO, grant lock and sticky error state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tag_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      lock_q  <= 1'b0;
      grant_q <= 1'b1;
      unexp_q <= 1'b0;
`ifdef MERLIN_MEM_ARB_RR_EN
      last_q  <= 1'b0;
`endif
    end else if (clk_en_i) begin
      if (accept) begin
        tag_q[wptr_q] <= grant;
        wptr_q        <= wptr_q + 1'b1;
`ifdef MERLIN_MEM_ARB_RR_EN
        last_q        <= grant;
`endif
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (accept && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (!accept && pop) begin
        level_q <= level_q - 1'b1;
      end
      if (mreqvalid_o && !mreqready_i) begin
        lock_q  <= 1'b1;
        grant_q <= grant;
      end else if (accept) begin
        lock_q <= 1'b0;
      end
      if (mrspvalid_i && empty) begin
        unexp_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_merlin_mem_arbiter.sv
// tb/tb_merlin_mem_arbiter.sv - directed self-checking bench for merlin_mem_arbiter (default fixed-priority build)
module tb_merlin_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        clk_en_i;
  logic        ireqvalid_i;
  logic        ireqready_o;
  logic [1:0]  ireqhpl_i;
  logic [31:0] ireqaddr_i;
  logic        irspvalid_o;
  logic        irspready_i;
  logic        irsprerr_o;
  logic [31:0] irspdata_o;
  logic        dreqvalid_i;
  logic        dreqready_o;
  logic [1:0]  dreqhpl_i;
  logic        dreqwr_i;
  logic [3:0]  dreqbe_i;
  logic [31:0] dreqaddr_i;
  logic [31:0] dreqwdata_i;
  logic        drspvalid_o;
  logic        drspready_i;
  logic        drsprerr_o;
  logic [31:0] drspdata_o;
  logic        mreqvalid_o;
  logic        mreqready_i;
  logic [1:0]  mreqhpl_o;
  logic        mreqwr_o;
  logic [3:0]  mreqbe_o;
  logic [31:0] mreqaddr_o;
  logic [31:0] mreqwdata_o;
  logic        mrspvalid_i;
  logic        mrspready_o;
  logic        mrsprerr_i;
  logic [31:0] mrspdata_i;
  logic [2:0]  outstanding_o;
  logic        unexp_rsp_o;

  int total = 0;
  int bad   = 0;

  merlin_mem_arbiter #(.C_OUTSTANDING_X(2), .C_XLEN(32)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
    .ireqvalid_i(ireqvalid_i), .ireqready_o(ireqready_o), .ireqhpl_i(ireqhpl_i), .ireqaddr_i(ireqaddr_i),
    .irspvalid_o(irspvalid_o), .irspready_i(irspready_i), .irsprerr_o(irsprerr_o), .irspdata_o(irspdata_o),
    .dreqvalid_i(dreqvalid_i), .dreqready_o(dreqready_o), .dreqhpl_i(dreqhpl_i), .dreqwr_i(dreqwr_i),
    .dreqbe_i(dreqbe_i), .dreqaddr_i(dreqaddr_i), .dreqwdata_i(dreqwdata_i),
    .drspvalid_o(drspvalid_o), .drspready_i(drspready_i), .drsprerr_o(drsprerr_o), .drspdata_o(drspdata_o),
    .mreqvalid_o(mreqvalid_o), .mreqready_i(mreqready_i), .mreqhpl_o(mreqhpl_o), .mreqwr_o(mreqwr_o),
    .mreqbe_o(mreqbe_o), .mreqaddr_o(mreqaddr_o), .mreqwdata_o(mreqwdata_o),
    .mrspvalid_i(mrspvalid_i), .mrspready_o(mrspready_o), .mrsprerr_i(mrsprerr_i), .mrspdata_i(mrspdata_i),
    .outstanding_o(outstanding_o), .unexp_rsp_o(unexp_rsp_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; clk_en_i = 1'b1;
    ireqvalid_i = 1'b1; ireqhpl_i = 2'd3; ireqaddr_i = 32'h0;
    irspready_i = 1'b1;
    dreqvalid_i = 1'b1; dreqhpl_i = 2'd0; dreqwr_i = 1'b0; dreqbe_i = 4'h0;
    dreqaddr_i = 32'h0; dreqwdata_i = 32'h0; drspready_i = 1'b1;
    mreqready_i = 1'b1; mrspvalid_i = 1'b1; mrsprerr_i = 1'b0; mrspdata_i = 32'h0;

    // reset cycle: every handshake output held low
    #1;
    chk("rst_mreqvalid", mreqvalid_o, 0);
    chk("rst_ireqready", ireqready_o, 0);
    chk("rst_dreqready", dreqready_o, 0);
    chk("rst_mrspready", mrspready_o, 0);
    chk("rst_irspvalid", irspvalid_o, 0);
    chk("rst_drspvalid", drspvalid_o, 0);
    tick(); tick();
    ireqvalid_i = 1'b0; dreqvalid_i = 1'b0; mrspvalid_i = 1'b0;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_unexp", unexp_rsp_o, 0);
    reset_i = 1'b0;
    tick();
    chk("idle_mreqvalid", mreqvalid_o, 0);
    chk("idle_outstanding", outstanding_o, 0);
    chk("idle_unexp", unexp_rsp_o, 0);

    // four back-to-back ifetch requests fill the tag FIFO
    ireqvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ireqaddr_i = 32'(4 * k);
      #1;
      chk("fill_mreqvalid", mreqvalid_o, 1);
      chk("fill_ireqready", ireqready_o, 1);
      chk("fill_addr", mreqaddr_o, 64'(4 * k));
      chk("fill_hpl", mreqhpl_o, 3);
      chk("fill_wr", mreqwr_o, 0);
      tick();
    end
    ireqaddr_i = 32'h10;
    #1;
    chk("full_ireqready", ireqready_o, 0);
    chk("full_mreqvalid", mreqvalid_o, 0);
    chk("full_outstanding", outstanding_o, 4);

    // full FIFO: pop and new request in the same cycle, request waits one cycle
    mrspvalid_i = 1'b1; mrspdata_i = 32'h1111;
    #1;
    chk("fullpop_irspvalid", irspvalid_o, 1);
    chk("fullpop_irspdata", irspdata_o, 32'h1111);
    chk("fullpop_mrspready", mrspready_o, 1);
    chk("fullpop_ireqready", ireqready_o, 0);
    tick();
    mrspvalid_i = 1'b0;
    #1;
    chk("fullpop_level3", outstanding_o, 3);
    chk("fullpop_ireqready_next", ireqready_o, 1);
    tick();
    ireqvalid_i = 1'b0;
    chk("fullpop_level4", outstanding_o, 4);

    // drain the four ifetch responses
    mrspvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mrspdata_i = 32'(k + 32'h20);
      #1;
      chk("drain_irspvalid", irspvalid_o, 1);
      chk("drain_drspvalid", drspvalid_o, 0);
      chk("drain_irspdata", irspdata_o, 64'(k + 32'h20));
      tick();
    end
    mrspvalid_i = 1'b0;
    chk("drain_level", outstanding_o, 0);
    chk("drain_unexp", unexp_rsp_o, 0);

    // simultaneous ifetch + data with memory stalled: data held three cycles
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h100;
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h200; dreqwr_i = 1'b0; dreqhpl_i = 2'd1;
    mreqready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_mreqvalid", mreqvalid_o, 1);
      chk("stall_addr", mreqaddr_o, 32'h200);
      chk("stall_dreqready", dreqready_o, 0);
      chk("stall_ireqready", ireqready_o, 0);
      tick();
    end
    mreqready_i = 1'b1;
    #1;
    chk("stall_dacc", dreqready_o, 1);
    chk("stall_hpl", mreqhpl_o, 1);
    tick();
    dreqvalid_i = 1'b0;
    #1;
    chk("stall_iacc", ireqready_o, 1);
    chk("stall_iaddr", mreqaddr_o, 32'h100);
    tick();
    ireqvalid_i = 1'b0;
    chk("stall_level", outstanding_o, 2);

    // responses routed data then ifetch; data side backpressure stalls the port
    mrspvalid_i = 1'b1; mrspdata_i = 32'hAAAA; drspready_i = 1'b0; mrsprerr_i = 1'b1;
    #1;
    chk("route_drspvalid", drspvalid_o, 1);
    chk("route_irspvalid0", irspvalid_o, 0);
    chk("route_bp_mrspready", mrspready_o, 0);
    chk("route_drsprerr", drsprerr_o, 1);
    tick();
    chk("route_bp_level", outstanding_o, 2);
    drspready_i = 1'b1; mrsprerr_i = 1'b0;
    #1;
    chk("route_mrspready", mrspready_o, 1);
    chk("route_drspdata", drspdata_o, 32'hAAAA);
    tick();
    mrspdata_i = 32'hBBBB;
    #1;
    chk("route_irspvalid", irspvalid_o, 1);
    chk("route_irspdata", irspdata_o, 32'hBBBB);
    chk("route_drspvalid0", drspvalid_o, 0);
    tick();
    mrspvalid_i = 1'b0;
    chk("route_level", outstanding_o, 0);

    // a stalled ifetch keeps its grant when data arrives later
    ireqvalid_i = 1'b1; ireqaddr_i = 32'h300; mreqready_i = 1'b0;
    tick();
    dreqvalid_i = 1'b1; dreqaddr_i = 32'h400; dreqwr_i = 1'b1; dreqbe_i = 4'hF; dreqwdata_i = 32'h55;
    #1;
    chk("lock_addr", mreqaddr_o, 32'h300);
    chk("lock_wr", mreqwr_o, 0);
    chk("lock_be", mreqbe_o, 0);
    mreqready_i = 1'b1;
    #1;
    chk("lock_iacc", ireqready_o, 1);
    chk("lock_dreqready0", dreqready_o, 0);
    tick();
    ireqvalid_i = 1'b0;
    #1;
    chk("lock_dacc", dreqready_o, 1);
    chk("lock_dwr", mreqwr_o, 1);
    chk("lock_dbe", mreqbe_o, 4'hF);
    chk("lock_dwdata", mreqwdata_o, 32'h55);
    tick();
    dreqvalid_i = 1'b0;
    chk("lock_level", outstanding_o, 2);
    mrspvalid_i = 1'b1;
    #1;
    chk("lock_rsp_i", irspvalid_o, 1);
    tick();
    chk("lock_rsp_d", drspvalid_o, 1);
    tick();
    mrspvalid_i = 1'b0;
    chk("lock_level0", outstanding_o, 0);

    // clock enable low: no acceptance and no state change
    clk_en_i = 1'b0; ireqvalid_i = 1'b1;
    #1;
    chk("cen_mreqvalid", mreqvalid_o, 0);
    tick();
    chk("cen_level", outstanding_o, 0);
    clk_en_i = 1'b1; ireqvalid_i = 1'b0;

    // stray response with empty FIFO: drained, sticky flag
    mrspvalid_i = 1'b1;
    #1;
    chk("unexp_mrspready", mrspready_o, 1);
    chk("unexp_irspvalid", irspvalid_o, 0);
    chk("unexp_drspvalid", drspvalid_o, 0);
    tick();
    mrspvalid_i = 1'b0;
    chk("unexp_set", unexp_rsp_o, 1);
    tick();
    chk("unexp_sticky", unexp_rsp_o, 1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("unexp_cleared", unexp_rsp_o, 0);
    mrspvalid_i = 1'b1;
    tick();
    mrspvalid_i = 1'b0;
    chk("unexp_post_reset", unexp_rsp_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
